// File: rtl/amb_yinelemeli_if.sv
// ---------------------------------------------------------------------------
// amb_yinelemeli_if
//   Request/result bus between the execute stage and the multi-cycle ALU
//   co-unit.
//   Request side : istek_gecerli_i, istek_hazir_o, istek_kod_i,
//                  istek_islec1_i, istek_islec2_i
//   Result side  : sonuc_gecerli_o, sonuc_hazir_i, sonuc_o
//   Status       : mesgul_o
//   Handshake: a transfer happens on a rising edge where both valid and ready
//   are high. Once valid is raised by a producer, its payload stays stable
//   until that edge. Ready may depend combinationally on state and flush,
//   but never on the valid signal of the same channel.
//   modport slave  : the co-unit
//   modport master : the requesting pipeline stage
// ---------------------------------------------------------------------------
interface amb_yinelemeli_if #(
  parameter int VERI_BIT = 32
);
  logic                istek_gecerli_i;
  logic                istek_hazir_o;
  logic [2:0]          istek_kod_i;
  logic [VERI_BIT-1:0] istek_islec1_i;
  logic [VERI_BIT-1:0] istek_islec2_i;
  logic                sonuc_gecerli_o;
  logic                sonuc_hazir_i;
  logic [VERI_BIT-1:0] sonuc_o;
  logic                mesgul_o;

  modport slave (
    input  istek_gecerli_i, istek_kod_i, istek_islec1_i, istek_islec2_i,
    input  sonuc_hazir_i,
    output istek_hazir_o, sonuc_gecerli_o, sonuc_o, mesgul_o
  );

  modport master (
    output istek_gecerli_i, istek_kod_i, istek_islec1_i, istek_islec2_i,
    output sonuc_hazir_i,
    input  istek_hazir_o, sonuc_gecerli_o, sonuc_o, mesgul_o
  );
endinterface

// File: rtl/amb_yinelemeli.sv
// ---------------------------------------------------------------------------
// amb_yinelemeli
//   Multi-cycle ALU co-unit. Bit-count ops (CNTP, CNTZ, CLZ, HMDST) examine
//   ADIM bits per cycle with a fixed latency; DIV/DIVU/REM/REMU run a
//   1-bit/cycle restoring divider on operand magnitudes and fix signs at the
//   end (truncating division). Divide-by-zero and signed overflow finish
//   immediately.
//   Ports:
//     clk_i   : clock, rising edge
//     rstn_i  : asynchronous active-low reset
//     iptal_i : flush, aborts the in-flight op and drops any held result
//     bus     : request/result bus (slave side)
//     durum_o : FSM state (0 BOS idle, 1 HESAPLA computing, 2 SONUC result)
// ---------------------------------------------------------------------------
module amb_yinelemeli #(
  parameter int VERI_BIT = 32,
  parameter int ADIM     = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  iptal_i,
  amb_yinelemeli_if.slave       bus,
  output logic [1:0]            durum_o
);

  localparam int SAYAC_BIT = $clog2(VERI_BIT) + 1;
  localparam int ADIM_SAYI = VERI_BIT / ADIM;

  localparam logic [2:0] K_CNTP  = 3'd0;
  localparam logic [2:0] K_CNTZ  = 3'd1;
  localparam logic [2:0] K_CLZ   = 3'd2;
  localparam logic [2:0] K_HMDST = 3'd3;

  typedef enum logic [1:0] {
    BOS     = 2'd0,
    HESAPLA = 2'd1,
    SONUC   = 2'd2
  } durum_t;

  durum_t                 r_durum;
  durum_t                 w_sonraki;

  logic [2:0]             r_kod;
  logic [VERI_BIT-1:0]    r_veri;     // count: shifting source, div: dividend/quotient
  logic [VERI_BIT-1:0]    r_kalan;    // partial remainder (always < divisor)
  logic [VERI_BIT-1:0]    r_bolen;
  logic [SAYAC_BIT-1:0]   r_acc;
  logic                   r_bulundu;  // first 1 already seen (CNTZ/CLZ)
  logic [SAYAC_BIT-1:0]   r_sayac;    // remaining steps minus one
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic [VERI_BIT-1:0]    r_sonuc;

  logic                   w_kabul;
  logic                   w_bolen_sifir;
  logic                   w_tasma;
  logic                   w_ozel;
  logic [VERI_BIT-1:0]    w_ters;
  logic [VERI_BIT-1:0]    w_abs1;
  logic [VERI_BIT-1:0]    w_abs2;
  logic [SAYAC_BIT-1:0]   w_parca;
  logic                   w_bul_sonraki;
  logic [SAYAC_BIT-1:0]   w_acc_yeni;
  logic [VERI_BIT:0]      w_kaydir;
  logic                   w_qbit;
  logic [VERI_BIT-1:0]    w_kalan_yeni;
  logic [VERI_BIT-1:0]    w_bolum_yeni;
  logic [VERI_BIT-1:0]    w_q_son;
  logic [VERI_BIT-1:0]    w_r_son;

  // ---------------- request decode ----------------
  assign w_kabul       = bus.istek_gecerli_i && bus.istek_hazir_o;
  assign w_bolen_sifir = (bus.istek_islec2_i == '0);
  assign w_tasma       = (bus.istek_islec1_i == {1'b1, {(VERI_BIT-1){1'b0}}}) &&
                         (bus.istek_islec2_i == '1);
  // Division results known at accept time skip HESAPLA entirely.
  assign w_ozel        = bus.istek_kod_i[2] &&
                         (w_bolen_sifir || (bus.istek_kod_i[1] && w_tasma));

  // Signed ops divide magnitudes; MIN_NEG magnitude is exact as unsigned.
  assign w_abs1 = (bus.istek_kod_i[1] && bus.istek_islec1_i[VERI_BIT-1]) ?
                  -bus.istek_islec1_i : bus.istek_islec1_i;
  assign w_abs2 = (bus.istek_kod_i[1] && bus.istek_islec2_i[VERI_BIT-1]) ?
                  -bus.istek_islec2_i : bus.istek_islec2_i;

  // CLZ reuses the LSB-first trailing-zero scan on the bit-reversed operand.
  always_comb begin
    w_ters = '0;
    for (int i = 0; i < VERI_BIT; i++) begin
      w_ters[i] = bus.istek_islec1_i[VERI_BIT-1-i];
    end
  end

  // ---------------- count step: low ADIM bits of r_veri ----------------
  always_comb begin
    w_parca       = '0;
    w_bul_sonraki = r_bulundu;
    for (int i = 0; i < ADIM; i++) begin
      if (r_kod == K_CNTP || r_kod == K_HMDST) begin
        w_parca = w_parca + {{(SAYAC_BIT-1){1'b0}}, r_veri[i]};
      end else if (!w_bul_sonraki) begin
        if (r_veri[i]) begin
          w_bul_sonraki = 1'b1;
        end else begin
          w_parca = w_parca + {{(SAYAC_BIT-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign w_acc_yeni = r_acc + w_parca;

  // ---------------- divide step ----------------
  // w_kaydir is the VERI_BIT+1-bit shifted partial remainder.
  assign w_kaydir     = {r_kalan, r_veri[VERI_BIT-1]};
  assign w_qbit       = (w_kaydir >= {1'b0, r_bolen});
  assign w_kalan_yeni = w_qbit ? VERI_BIT'(w_kaydir - {1'b0, r_bolen})
                               : w_kaydir[VERI_BIT-1:0];
  assign w_bolum_yeni = {r_veri[VERI_BIT-2:0], w_qbit};
  assign w_q_son      = r_neg_q ? -w_bolum_yeni : w_bolum_yeni;
  assign w_r_son      = r_neg_r ? -w_kalan_yeni : w_kalan_yeni;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_durum <= BOS;
    end else begin
      r_durum <= w_sonraki;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      BOS:     if (w_kabul) w_sonraki = w_ozel ? SONUC : HESAPLA;
      HESAPLA: if (r_sayac == '0) w_sonraki = SONUC;
      SONUC:   if (bus.sonuc_hazir_i) w_sonraki = BOS;
      default: w_sonraki = BOS;
    endcase
    if (iptal_i) w_sonraki = BOS;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.istek_hazir_o   = (r_durum == BOS) && !iptal_i;
    bus.sonuc_gecerli_o = (r_durum == SONUC);
    bus.mesgul_o        = (r_durum != BOS);
    bus.sonuc_o         = r_sonuc;
    durum_o             = r_durum;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_kod     <= '0;
      r_veri    <= '0;
      r_kalan   <= '0;
      r_bolen   <= '0;
      r_acc     <= '0;
      r_bulundu <= 1'b0;
      r_sayac   <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sonuc   <= '0;
    end else if (w_kabul) begin
      r_kod     <= bus.istek_kod_i;
      r_acc     <= '0;
      r_bulundu <= 1'b0;
      r_kalan   <= '0;
      if (!bus.istek_kod_i[2]) begin
        r_sayac <= SAYAC_BIT'(ADIM_SAYI - 1);
        if (bus.istek_kod_i == K_CLZ) begin
          r_veri <= w_ters;
        end else if (bus.istek_kod_i == K_HMDST) begin
          r_veri <= bus.istek_islec1_i ^ bus.istek_islec2_i;
        end else begin
          r_veri <= bus.istek_islec1_i;
        end
      end else begin
        r_sayac <= SAYAC_BIT'(VERI_BIT - 1);
        r_veri  <= w_abs1;
        r_bolen <= w_abs2;
        r_neg_q <= bus.istek_kod_i[1] &
                   (bus.istek_islec1_i[VERI_BIT-1] ^ bus.istek_islec2_i[VERI_BIT-1]);
        r_neg_r <= bus.istek_kod_i[1] & bus.istek_islec1_i[VERI_BIT-1];
        if (w_bolen_sifir) begin
          r_sonuc <= bus.istek_kod_i[0] ? bus.istek_islec1_i : '1;
        end else if (bus.istek_kod_i[1] && w_tasma) begin
          r_sonuc <= bus.istek_kod_i[0] ? '0 : bus.istek_islec1_i;
        end
      end
    end else if (r_durum == HESAPLA && !iptal_i) begin
      r_sayac <= r_sayac - 1'b1;
      if (!r_kod[2]) begin
        r_veri    <= r_veri >> ADIM;
        r_acc     <= w_acc_yeni;
        r_bulundu <= w_bul_sonraki;
        if (r_sayac == '0) r_sonuc <= VERI_BIT'(w_acc_yeni);
      end else begin
        r_veri  <= w_bolum_yeni;
        r_kalan <= w_kalan_yeni;
        if (r_sayac == '0) r_sonuc <= r_kod[0] ? w_r_son : w_q_son;
      end
    end
  end

endmodule

// File: tb/tb_amb_yinelemeli.sv
// ---------------------------------------------------------------------------
// tb_amb_yinelemeli
//   Randomised and directed bench for amb_yinelemeli (VERI_BIT=32, ADIM=4).
//   Results are compared against a plain-arithmetic reference model through
//   an expected-value queue; latency, backpressure, flush and reset are
//   checked directly.
// ---------------------------------------------------------------------------
module tb_amb_yinelemeli;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rstn;
  logic       iptal;
  logic [1:0] durum;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  amb_yinelemeli_if #(.VERI_BIT(W)) bus();

  amb_yinelemeli #(.VERI_BIT(W), .ADIM(4)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .iptal_i (iptal),
    .bus     (bus),
    .durum_o (durum)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_hata = 0;

  task automatic kontrol(input string etiket, input logic [W-1:0] gozlenen,
                         input logic [W-1:0] beklenen);
    n_vec++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [2:0] kod,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    int n;
    r = '0;
    case (kod)
      3'd0: r = $countones(a);
      3'd1: begin n = 0; while (n < W && a[n] == 1'b0) n++; r = n; end
      3'd2: begin n = 0; while (n < W && a[W-1-n] == 1'b0) n++; r = n; end
      3'd3: r = $countones(a ^ b);
      3'd4: r = (b == 0) ? '1 : a / b;
      3'd5: r = (b == 0) ? a : a % b;
      3'd6: if (b == 0) r = '1;
            else if (a == MIN_NEG && b == '1) r = MIN_NEG;
            else r = $signed(a) / $signed(b);
      3'd7: if (b == 0) r = a;
            else if (a == MIN_NEG && b == '1) r = '0;
            else r = $signed(a) % $signed(b);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_gecikme(input logic [2:0] kod, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (kod < 3'd4) return W / 4;
    if (b == 0) return 0;
    if (kod[1] && a == MIN_NEG && b == '1) return 0;
    return W;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a request, returns the number of the edge that accepts it.
  // Returns at the negedge right after that edge, with inputs scrambled.
  task automatic istek_gonder(input logic [2:0] kod, input logic [W-1:0] a,
                              input logic [W-1:0] b, output int n_kabul);
    int bekle;
    bekle = 0;
    @(negedge clk);
    bus.istek_gecerli_i = 1'b1;
    bus.istek_kod_i     = kod;
    bus.istek_islec1_i  = a;
    bus.istek_islec2_i  = b;
    while (!bus.istek_hazir_o && bekle < 60) begin
      @(negedge clk);
      bekle++;
    end
    kontrol("istek_hazir", {31'd0, bus.istek_hazir_o}, 32'd1);
    n_kabul = cyc + 1;
    @(negedge clk);
    bus.istek_gecerli_i = 1'b0;
    bus.istek_kod_i     = 3'($urandom_range(0, 7));
    bus.istek_islec1_i  = $urandom;
    bus.istek_islec2_i  = $urandom;
  endtask

  // Full operation: request, wait for result, optional backpressure, drain.
  task automatic islem(input logic [2:0] kod, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int geri_basinc);
    int n_kabul;
    int bekle;
    logic [W-1:0] tut;
    bus.sonuc_hazir_i = (geri_basinc == 0);
    istek_gonder(kod, a, b, n_kabul);
    exp_q.push_back(ref_model(kod, a, b));
    bekle = 0;
    while (!bus.sonuc_gecerli_o && bekle < 45) begin
      @(negedge clk);
      bekle++;
    end
    kontrol("sonuc_gecerli", {31'd0, bus.sonuc_gecerli_o}, 32'd1);
    kontrol("gecikme", cyc - n_kabul, ref_gecikme(kod, a, b));
    kontrol($sformatf("sonuc kod=%0d a=%08h b=%08h", kod, a, b), bus.sonuc_o, exp_q.pop_front());
    for (int i = 0; i < geri_basinc; i++) begin
      tut = bus.sonuc_o;
      @(negedge clk);
      kontrol("bp_sonuc_sabit", bus.sonuc_o, tut);
      kontrol("bp_gecerli", {31'd0, bus.sonuc_gecerli_o}, 32'd1);
      kontrol("bp_istek_hazir", {31'd0, bus.istek_hazir_o}, 32'd0);
    end
    bus.sonuc_hazir_i = 1'b1;
    @(negedge clk);
    kontrol("bosalt_mesgul", {31'd0, bus.mesgul_o}, 32'd0);
    kontrol("bosalt_gecerli", {31'd0, bus.sonuc_gecerli_o}, 32'd0);
  endtask

  task automatic sonuc_yok(input string etiket, input int dongu);
    logic goruldu;
    goruldu = 1'b0;
    repeat (dongu) begin
      @(negedge clk);
      if (bus.sonuc_gecerli_o) goruldu = 1'b1;
    end
    kontrol(etiket, {31'd0, goruldu}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [2:0]   kod;
    logic [W-1:0] a, b;
    int bp;

    rstn = 1'b0;
    iptal = 1'b0;
    bus.istek_gecerli_i = 1'b0;
    bus.istek_kod_i     = '0;
    bus.istek_islec1_i  = '0;
    bus.istek_islec2_i  = '0;
    bus.sonuc_hazir_i   = 1'b1;

    #3;
    kontrol("rst_sonuc", bus.sonuc_o, 32'd0);
    kontrol("rst_gecerli", {31'd0, bus.sonuc_gecerli_o}, 32'd0);
    kontrol("rst_mesgul", {31'd0, bus.mesgul_o}, 32'd0);
    kontrol("rst_istek_hazir", {31'd0, bus.istek_hazir_o}, 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // directed cases
    islem(3'd0, 32'hF0F0_000F, 32'h0, 0);
    islem(3'd1, 32'h0, 32'h0, 0);
    islem(3'd2, 32'h0001_0000, 32'h0, 0);
    islem(3'd2, 32'h0, 32'h0, 0);
    islem(3'd1, 32'h8000_0000, 32'h0, 0);
    islem(3'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 0);
    islem(3'd6, -32'sd7, 32'd2, 0);
    islem(3'd7, -32'sd7, 32'd2, 0);
    islem(3'd4, 32'd100, 32'd7, 0);
    islem(3'd5, 32'd100, 32'd7, 0);
    islem(3'd4, 32'h1234_5678, 32'd0, 0);
    islem(3'd5, 32'd5, 32'd0, 0);
    islem(3'd6, MIN_NEG, 32'hFFFF_FFFF, 0);
    islem(3'd7, MIN_NEG, 32'hFFFF_FFFF, 0);
    islem(3'd6, 32'd7, 32'd0, 0);
    islem(3'd4, 32'hFFFF_FFFF, 32'd1, 0);

    // backpressure held for 5 cycles
    islem(3'd0, 32'hDEAD_BEEF, 32'h0, 5);

    // flush mid-divide with a competing request
    bus.sonuc_hazir_i = 1'b1;
    istek_gonder(3'd6, -32'sd7, 32'd2, n);
    repeat (3) @(negedge clk);
    iptal = 1'b1;
    bus.istek_gecerli_i = 1'b1;
    bus.istek_kod_i     = 3'd0;
    bus.istek_islec1_i  = 32'hFFFF_FFFF;
    #1;
    kontrol("iptal_istek_hazir", {31'd0, bus.istek_hazir_o}, 32'd0);
    @(negedge clk);
    iptal = 1'b0;
    bus.istek_gecerli_i = 1'b0;
    kontrol("iptal_mesgul", {31'd0, bus.mesgul_o}, 32'd0);
    kontrol("iptal_durum", {30'd0, durum}, 32'd0);
    sonuc_yok("iptal_sonuc_yok", 40);

    // flush while a result is held
    bus.sonuc_hazir_i = 1'b0;
    istek_gonder(3'd1, 32'h10, 32'h0, n);
    repeat (10) @(negedge clk);
    kontrol("tutulan_gecerli", {31'd0, bus.sonuc_gecerli_o}, 32'd1);
    iptal = 1'b1;
    @(negedge clk);
    iptal = 1'b0;
    kontrol("iptal_tutulan_gecerli", {31'd0, bus.sonuc_gecerli_o}, 32'd0);
    kontrol("iptal_tutulan_mesgul", {31'd0, bus.mesgul_o}, 32'd0);
    bus.sonuc_hazir_i = 1'b1;

    // async reset mid-CNTP
    istek_gonder(3'd0, 32'hFFFF_FFFF, 32'h0, n);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    kontrol("arst_sonuc", bus.sonuc_o, 32'd0);
    kontrol("arst_gecerli", {31'd0, bus.sonuc_gecerli_o}, 32'd0);
    kontrol("arst_mesgul", {31'd0, bus.mesgul_o}, 32'd0);
    kontrol("arst_istek_hazir", {31'd0, bus.istek_hazir_o}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    sonuc_yok("arst_sonuc_yok", 15);

    // randomised operations
    for (int t = 0; t < 50; t++) begin
      kod = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: a = MIN_NEG;
        1: a = $urandom_range(0, 300);
        2: a = '0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = '1;
        2: b = $urandom_range(1, 20);
        3: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      bp = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      islem(kod, a, b, bp);
    end

    kontrol("kuyruk_bos", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_hata);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
